// File: rtl/cle_label_stats_pkg.sv
// Shared types and widths for the CLE label statistics stage.
// CLE_STATS_CENTROID_EN adds per-object row/column sum fields to obj_entry_t.
package cle_stats_pkg;

  localparam int IMG_DIM = 32;
  localparam int ADDR_W  = 10;
  localparam int LBL_W   = 8;
  localparam int AREA_W  = 11;
  localparam int COORD_W = 5;
  localparam int SUM_W   = 15;
  localparam int CNT_W   = 4;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_DIM * IMG_DIM - 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    EMIT,
    FIN
  } state_t;

  typedef struct packed {
    logic [LBL_W-1:0]   label;
    logic [AREA_W-1:0]  area;
    logic [COORD_W-1:0] rmin;
    logic [COORD_W-1:0] rmax;
    logic [COORD_W-1:0] cmin;
    logic [COORD_W-1:0] cmax;
`ifdef CLE_STATS_CENTROID_EN
    logic [SUM_W-1:0]   rsum;
    logic [SUM_W-1:0]   csum;
`endif
  } obj_entry_t;

  function automatic logic [COORD_W-1:0] addr_row(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] addr_col(input logic [ADDR_W-1:0] a);
    return a[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/cle_label_stats_if.sv
// Object record stream (valid/ready) from the label statistics stage.
// CLE_STATS_CENTROID_EN adds the rsum/csum record fields.
interface cle_label_stats_if;
  import cle_stats_pkg::*;

  logic               valid;
  logic               ready;
  logic [LBL_W-1:0]   label;
  logic [AREA_W-1:0]  area;
  logic [COORD_W-1:0] rmin;
  logic [COORD_W-1:0] rmax;
  logic [COORD_W-1:0] cmin;
  logic [COORD_W-1:0] cmax;
`ifdef CLE_STATS_CENTROID_EN
  logic [SUM_W-1:0]   rsum;
  logic [SUM_W-1:0]   csum;

  modport master (output valid, label, area, rmin, rmax, cmin, cmax, rsum, csum,
                  input  ready);
  modport slave  (input  valid, label, area, rmin, rmax, cmin, cmax, rsum, csum,
                  output ready);
`else
  modport master (output valid, label, area, rmin, rmax, cmin, cmax,
                  input  ready);
  modport slave  (input  valid, label, area, rmin, rmax, cmin, cmax,
                  output ready);
`endif

endinterface

// File: rtl/cle_label_stats_entry.sv
// One object table entry: label match plus area / bounding-box accumulation.
// CLE_STATS_CENTROID_EN adds row/column sum accumulators.
module cle_stats_entry
  import cle_stats_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               alloc,
  input  logic               valid,
  input  logic               px_en,
  input  logic [LBL_W-1:0]   px_label,
  input  logic [COORD_W-1:0] px_row,
  input  logic [COORD_W-1:0] px_col,
  output logic               hit,
  output obj_entry_t         ent
);

  // Allocation and update commit on the same edge, so the next pixel already
  // compares against the freshly written label.
  assign hit = valid && px_en && (ent.label == px_label);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent <= '0;
    end else if (clear) begin
      ent <= '0;
    end else if (alloc) begin
      ent.label <= px_label;
      ent.area  <= AREA_W'(1);
      ent.rmin  <= px_row;
      ent.rmax  <= px_row;
      ent.cmin  <= px_col;
      ent.cmax  <= px_col;
`ifdef CLE_STATS_CENTROID_EN
      ent.rsum  <= SUM_W'(px_row);
      ent.csum  <= SUM_W'(px_col);
`endif
    end else if (hit) begin
      ent.area <= ent.area + AREA_W'(1);
      if (px_row < ent.rmin) ent.rmin <= px_row;
      if (px_row > ent.rmax) ent.rmax <= px_row;
      if (px_col < ent.cmin) ent.cmin <= px_col;
      if (px_col > ent.cmax) ent.cmax <= px_col;
`ifdef CLE_STATS_CENTROID_EN
      ent.rsum <= ent.rsum + SUM_W'(px_row);
      ent.csum <= ent.csum + SUM_W'(px_col);
`endif
    end
  end

endmodule

// File: rtl/cle_label_stats.sv
// Raster-scans the CLE label image and streams one record per object in order
// of first appearance. CLE_STATS_CENTROID_EN adds row/column sums to each record.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing SRAM reads 0..1023, processing the previous word
// DRAIN | processing the final word (address 1023)
// EMIT  | presenting records 0..obj_cnt-1 on the stream
// FIN   | one-cycle done pulse
module cle_label_stats
  import cle_stats_pkg::*;
#(
  parameter int MAX_OBJ = 8
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  sram_a,
  input  logic [LBL_W-1:0]   sram_q,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [CNT_W-1:0]   obj_cnt,
  cle_label_stats_if.master  obj
);

  state_t             state_q, state_d;
  logic               pipe_vld;
  logic [ADDR_W-1:0]  pipe_addr;
  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt_d;
  logic               clear, px_en, any_hit, alloc_en, ovf_set;
  logic               emit, hs, last_idx;
  logic [COORD_W-1:0] px_row, px_col;
  logic [MAX_OBJ-1:0] hit;
  obj_entry_t         tbl [MAX_OBJ];
  obj_entry_t         sel;

  assign clear    = (state_q == IDLE) && start;
  assign px_en    = pipe_vld && (sram_q != '0);
  assign any_hit  = |hit;
  assign alloc_en = px_en && !any_hit && (obj_cnt < CNT_W'(MAX_OBJ));
  assign ovf_set  = px_en && !any_hit && (obj_cnt >= CNT_W'(MAX_OBJ));
  assign cnt_d    = obj_cnt + CNT_W'(alloc_en);
  assign px_row   = addr_row(pipe_addr);
  assign px_col   = addr_col(pipe_addr);

  assign emit     = (state_q == EMIT);
  assign hs       = emit && obj.ready;
  assign last_idx = (idx == obj_cnt - CNT_W'(1));
  assign busy     = (state_q == SCAN) || (state_q == DRAIN) || (state_q == EMIT);
  assign done     = (state_q == FIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (sram_a == ADDR_LAST) state_d = DRAIN;
      // count must include an allocation made by the final word
      DRAIN:   state_d = (cnt_d != '0) ? EMIT : FIN;
      EMIT:    if (hs && last_idx) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sram_a    <= '0;
      pipe_vld  <= 1'b0;
      pipe_addr <= '0;
      obj_cnt   <= '0;
      overflow  <= 1'b0;
      idx       <= '0;
    end else begin
      pipe_vld  <= (state_q == SCAN);
      pipe_addr <= sram_a;
      if (clear) begin
        sram_a   <= '0;
        obj_cnt  <= '0;
        overflow <= 1'b0;
        idx      <= '0;
      end else begin
        if ((state_q == SCAN) && (sram_a != ADDR_LAST)) sram_a <= sram_a + ADDR_W'(1);
        obj_cnt <= cnt_d;
        if (ovf_set) overflow <= 1'b1;
        if (hs)      idx      <= idx + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < MAX_OBJ; i++) begin : g_ent
    cle_stats_entry u_ent (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .alloc    (alloc_en && (obj_cnt == CNT_W'(i))),
      .valid    (obj_cnt > CNT_W'(i)),
      .px_en    (px_en),
      .px_label (sram_q),
      .px_row   (px_row),
      .px_col   (px_col),
      .hit      (hit[i]),
      .ent      (tbl[i])
    );
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < MAX_OBJ; i++) begin
      if (idx == CNT_W'(i)) sel = tbl[i];
    end
  end

  // Record fields read as zero whenever no record is offered.
  always_comb begin
    obj.valid = emit;
    obj.label = '0;
    obj.area  = '0;
    obj.rmin  = '0;
    obj.rmax  = '0;
    obj.cmin  = '0;
    obj.cmax  = '0;
`ifdef CLE_STATS_CENTROID_EN
    obj.rsum  = '0;
    obj.csum  = '0;
`endif
    if (emit) begin
      obj.label = sel.label;
      obj.area  = sel.area;
      obj.rmin  = sel.rmin;
      obj.rmax  = sel.rmax;
      obj.cmin  = sel.cmin;
      obj.cmax  = sel.cmax;
`ifdef CLE_STATS_CENTROID_EN
      obj.rsum  = sel.rsum;
      obj.csum  = sel.csum;
`endif
    end
  end

endmodule

// File: tb/tb_cle_label_stats.sv
// Randomized bench for cle_label_stats against an image-level reference model.
// CLE_STATS_CENTROID_EN also checks the row/column sum fields.
module tb_cle_label_stats;

  localparam int MAX_OBJ = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] sram_a;
  logic [7:0] sram_q;
  logic       busy, done, overflow;
  logic [3:0] obj_cnt;

  cle_label_stats_if obj_if ();

  cle_label_stats #(.MAX_OBJ(MAX_OBJ)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .sram_a   (sram_a),
    .sram_q   (sram_q),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .obj_cnt  (obj_cnt),
    .obj      (obj_if)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  always @(posedge clk) sram_q <= mem[sram_a];

  int n_cmp = 0;
  int n_bad = 0;

  int m_n;
  bit m_ovf;
  int m_label [MAX_OBJ];
  int m_area  [MAX_OBJ];
  int m_rmin  [MAX_OBJ];
  int m_rmax  [MAX_OBJ];
  int m_cmin  [MAX_OBJ];
  int m_cmax  [MAX_OBJ];
  int m_rsum  [MAX_OBJ];
  int m_csum  [MAX_OBJ];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Object list in order of first appearance, straight from the image.
  task automatic build_model();
    int l, r, c, f;
    m_n = 0;
    m_ovf = 1'b0;
    for (int a = 0; a < 1024; a++) begin
      l = int'(mem[a]);
      r = a / 32;
      c = a % 32;
      if (l != 0) begin
        f = -1;
        for (int i = 0; i < m_n; i++) if (m_label[i] == l) f = i;
        if (f >= 0) begin
          m_area[f]++;
          if (r < m_rmin[f]) m_rmin[f] = r;
          if (r > m_rmax[f]) m_rmax[f] = r;
          if (c < m_cmin[f]) m_cmin[f] = c;
          if (c > m_cmax[f]) m_cmax[f] = c;
          m_rsum[f] += r;
          m_csum[f] += c;
        end else if (m_n < MAX_OBJ) begin
          m_label[m_n] = l;
          m_area[m_n]  = 1;
          m_rmin[m_n]  = r;
          m_rmax[m_n]  = r;
          m_cmin[m_n]  = c;
          m_cmax[m_n]  = c;
          m_rsum[m_n]  = r;
          m_csum[m_n]  = c;
          m_n++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
  endtask

  task automatic fill_rand(input int k, input int dens);
    int pool [16];
    for (int i = 0; i < k; i++) pool[i] = $urandom_range(1, 255);
    for (int a = 0; a < 1024; a++)
      mem[a] = ($urandom_range(0, 99) < dens) ? 8'(pool[$urandom_range(0, k - 1)]) : 8'd0;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready pattern 1,0,0,1
  task automatic run_scan(input int mode);
    int sweep_bad, first_out, hs_n, last_hs, done_n, done_c, stall_bad, vcnt;
    logic [69:0] rec, prev_rec;
    bit prev_stall, rdy;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    build_model();
    sweep_bad = 0; first_out = -1; hs_n = 0; last_hs = -1;
    done_n = 0; done_c = -1; stall_bad = 0; vcnt = 0;
    prev_stall = 1'b0; prev_rec = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_eq("busy_scan", busy, 1);
    for (int c = 0; c < 4000; c++) begin
      if (c < 1024 && sram_a !== 10'(c)) sweep_bad++;
      if (first_out < 0 && (obj_if.valid || done)) first_out = c;
      if (done) begin done_n++; done_c = c; end
`ifdef CLE_STATS_CENTROID_EN
      rec = {obj_if.valid, obj_if.label, obj_if.area, obj_if.rmin, obj_if.rmax,
             obj_if.cmin, obj_if.cmax, obj_if.rsum, obj_if.csum};
`else
      rec = {obj_if.valid, obj_if.label, obj_if.area, obj_if.rmin, obj_if.rmax,
             obj_if.cmin, obj_if.cmax, 30'd0};
`endif
      if (prev_stall && rec !== prev_rec) stall_bad++;
      if (obj_if.valid) begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = pat[vcnt % 4];
        endcase
        vcnt++;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      obj_if.ready = rdy;
      if (obj_if.valid && rdy) begin
        if (hs_n < m_n) begin
          check_eq($sformatf("r%0d_label", hs_n), obj_if.label, m_label[hs_n]);
          check_eq($sformatf("r%0d_area", hs_n), obj_if.area, m_area[hs_n]);
          check_eq($sformatf("r%0d_rmin", hs_n), obj_if.rmin, m_rmin[hs_n]);
          check_eq($sformatf("r%0d_rmax", hs_n), obj_if.rmax, m_rmax[hs_n]);
          check_eq($sformatf("r%0d_cmin", hs_n), obj_if.cmin, m_cmin[hs_n]);
          check_eq($sformatf("r%0d_cmax", hs_n), obj_if.cmax, m_cmax[hs_n]);
`ifdef CLE_STATS_CENTROID_EN
          check_eq($sformatf("r%0d_rsum", hs_n), obj_if.rsum, m_rsum[hs_n]);
          check_eq($sformatf("r%0d_csum", hs_n), obj_if.csum, m_csum[hs_n]);
`endif
        end
        hs_n++;
        last_hs = c;
      end
      prev_stall = obj_if.valid && !rdy;
      prev_rec = rec;
      if (done_c >= 0 && c >= done_c + 2) break;
      @(negedge clk);
    end
    obj_if.ready = 1'b0;
    check_eq("addr_sweep_errs", sweep_bad, 0);
    check_eq("first_out_cycle", first_out, 1025);
    check_eq("handshakes", hs_n, m_n);
    check_eq("stall_unstable", stall_bad, 0);
    check_eq("done_pulses", done_n, 1);
    if (m_n > 0) check_eq("done_after_last_hs", done_c, last_hs + 1);
    check_eq("obj_cnt", obj_cnt, m_n);
    check_eq("overflow", overflow, m_ovf);
    check_eq("busy_after_done", busy, 0);
    check_eq("sram_a_hold", sram_a, 1023);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, done, 0);
    check_eq({pfx, "_ovf"}, overflow, 0);
    check_eq({pfx, "_cnt"}, obj_cnt, 0);
    check_eq({pfx, "_valid"}, obj_if.valid, 0);
    check_eq({pfx, "_sram_a"}, sram_a, 0);
    check_eq({pfx, "_label"}, obj_if.label, 0);
  endtask

  initial begin
    obj_if.ready = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_zero_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // all background
    run_scan(0);

    // 3x4 block of label 0x05
    clear_mem();
    for (int r = 3; r <= 6; r++)
      for (int c = 10; c <= 12; c++) mem[r * 32 + c] = 8'h05;
    run_scan(0);

    // adjacent first appearances plus a far corner pixel
    clear_mem();
    mem[0] = 8'h07;
    mem[1] = 8'h02;
    mem[1023] = 8'h07;
    run_scan(0);

    // nine distinct labels, one pixel each
    clear_mem();
    for (int i = 0; i < 9; i++)
      mem[i * 100 + $urandom_range(0, 99)] = 8'(i * 20 + $urandom_range(1, 19));
    run_scan(1);

    // two objects with ready 1,0,0,1
    clear_mem();
    for (int r = 2; r <= 4; r++) mem[r * 32 + 5] = 8'h33;
    for (int c = 20; c <= 27; c++) mem[17 * 32 + c] = 8'hC1;
    run_scan(2);

    // reset in the middle of a scan, then a fresh scan
    fill_rand(4, 40);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(negedge clk) rst_n = 1'b1;
    fill_rand(3, 30);
    run_scan(0);

    // random images, some overflowing the table
    for (int t = 0; t < 6; t++) begin
      fill_rand($urandom_range(1, 12), $urandom_range(5, 60));
      run_scan(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
